// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the boot byte stream and the instruction-memory write port that
//   connect to imem_loader.
//   rx_data/rx_valid/rx_ready : byte stream, valid/ready handshake
//   imem_we/imem_addr/imem_wdata : one-word-per-strobe memory write port
//   slave  : the loader side (consumes bytes, drives the memory port)
//   master : the source/observer side (drives bytes, watches the memory port)
interface imem_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the instruction memory. Receives LEN, 4*LEN data
//   bytes (little-endian words) and an XOR checksum byte, writes each word to
//   consecutive addresses from 0, and keeps the core in reset until a whole,
//   verified image is present.
//   clk, reset : single clock, synchronous active-high reset
//   start      : one-cycle pulse, begins a session from IDLE/DONE/ERR
//   bus        : byte stream in, memory write port out (imem_loader_if.slave)
//   core_hold  : 1 keeps the core in reset (low only in DONE)
//   busy       : session in progress
//   done       : image loaded and checksum matched
//   err        : session aborted (bad length or checksum mismatch)
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_LEN   | accepting the length byte
// S_DATA  | accepting the 4 bytes of the current word
// S_WRITE | one-cycle imem write of the assembled word
// S_CSUM  | accepting the checksum byte
// S_DONE  | image verified, core released
// S_ERR   | session aborted, core held
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0]        DEPTH_B = 8'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_words_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [1:0]        byte_cnt_q;
  logic [7:0]        acc_q;
  logic [31:0]       word_q;

  logic              accept;
  logic              len_bad;
  logic              last_word;
  logic [ADDR_W:0]   idx_p1;

  // rx_ready is a pure state decode, so it never depends on rx_valid.
  assign bus.rx_ready = (state_q == S_LEN) || (state_q == S_DATA) ||
                        (state_q == S_CSUM);
  assign accept       = bus.rx_valid && bus.rx_ready;

  assign len_bad   = (bus.rx_data == 8'd0) || (bus.rx_data > DEPTH_B);
  assign idx_p1    = {1'b0, word_idx_q} + CNT_ONE;
  assign last_word = (idx_p1 == n_words_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          state_d = len_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_cnt_q == 2'd3)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (bus.rx_data == acc_q) ? S_DONE : S_ERR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_words_q  <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      acc_q      <= '0;
      word_q     <= '0;
    end else begin
      case (state_q)
        S_LEN: begin
          if (accept) begin
            n_words_q  <= bus.rx_data[ADDR_W:0];
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            acc_q      <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            case (byte_cnt_q)
              2'd0:    word_q[7:0]   <= bus.rx_data;
              2'd1:    word_q[15:8]  <= bus.rx_data;
              2'd2:    word_q[23:16] <= bus.rx_data;
              default: word_q[31:24] <= bus.rx_data;
            endcase
            acc_q      <= acc_q ^ bus.rx_data;
            // wraps 3 -> 0, ready for the next word
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        S_WRITE: begin
          // Holding on the last word keeps the index inside 0..DEPTH-1
          // even for a full-depth image.
          if (!last_word) begin
            word_idx_q <= word_idx_q + IDX_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = word_idx_q;
  assign bus.imem_wdata = word_q;

  assign busy      = (state_q == S_LEN) || (state_q == S_DATA) ||
                     (state_q == S_WRITE) || (state_q == S_CSUM);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign core_hold = (state_q != S_DONE);

endmodule
